pcileech_tx_serializer: RTL and testbench

Downstream stage of the 256-bit status/data multiplexer: accepts each 256-bit frame (one status word plus seven data words), buffers it in a small frame FIFO, and serializes it into eight 32-bit beats for the FT601 transmit path. It drives the multiplexer's `rd_en` flow-control input with a registered almost-full-derived ready and absorbs the multiplexer's in-flight frames without loss.

---
 rtl/pcileech_tx_pkg.sv | 14 +
 rtl/pcileech_tx_serializer_if.sv | 24 ++
 rtl/pcileech_tx_frame_fifo.sv | 50 +++++
 rtl/pcileech_tx_serializer.sv | 98 +++++++++
 tb/tb_pcileech_tx_serializer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_tx_pkg.sv
// rtl/pcileech_tx_pkg.sv - shared constants and types for the FT601 transmit serializer
package pcileech_tx_pkg;

  localparam int TX_WORD_W = 32;
  localparam int TX_BEATS  = 8;
  localparam int FRAME_W   = 256;
  localparam logic [TX_WORD_W-1:0] FILLER_STATUS = 32'hFFFFFFEF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/pcileech_tx_serializer_if.sv
// rtl/pcileech_tx_serializer_if.sv - frame input and beat output signals of the transmit serializer
interface pcileech_tx_serializer_if;
  import pcileech_tx_pkg::*;

  logic [FRAME_W-1:0]   din;
  logic                 din_valid;
  logic                 din_ready;
  logic [TX_WORD_W-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 overflow;
  logic [3:0]           level;

  modport master (
    output din, din_valid, tx_ready,
    input  din_ready, tx_data, tx_valid, overflow, level
  );

  modport slave (
    input  din, din_valid, tx_ready,
    output din_ready, tx_data, tx_valid, overflow, level
  );

endinterface

// File: rtl/pcileech_tx_frame_fifo.sv
// rtl/pcileech_tx_frame_fifo.sv - 256-bit frame ring buffer with occupancy, full and empty
module pcileech_tx_frame_fifo
  import pcileech_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [FRAME_W-1:0]       i_din,
  input  logic                     i_pop,
  output logic [FRAME_W-1:0]       o_dout,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/pcileech_tx_serializer.sv
// rtl/pcileech_tx_serializer.sv - buffers 256-bit mux frames and emits them as eight 32-bit beats, status first
module pcileech_tx_serializer
  import pcileech_tx_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 3
) (
  input logic               clk,
  input logic               rst,
  pcileech_tx_serializer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(TX_BEATS);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(DEPTH - AFULL_MARGIN);

  tx_state_e          r_state;
  tx_state_e          w_state_next;
  logic [BW-1:0]      r_beat;
  logic [FRAME_W-1:0] r_shift;
  logic               r_din_ready;
  logic               r_overflow;

  logic [FRAME_W-1:0] w_head;
  logic [AW:0]        w_level;
  logic [AW:0]        w_level_next;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_accept;

  pcileech_tx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (bus.din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_accept = (r_state == ST_SEND) && bus.tx_ready;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_accept && (r_beat == '0)) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A full FIFO still takes a frame when the head leaves in the same cycle.
  assign w_push       = bus.din_valid && (!w_full || w_pop);
  assign w_level_next = w_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_shift     <= '0;
      r_din_ready <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_din_ready <= (w_level_next <= AFULL_LVL);
      if (bus.din_valid && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_pop) begin
        r_shift <= w_head;
        r_beat  <= BW'(TX_BEATS - 1);
      end else if (w_accept) begin
        r_shift <= {r_shift[FRAME_W-TX_WORD_W-1:0], {TX_WORD_W{1'b0}}};
        r_beat  <= r_beat - 1'b1;
      end
    end
  end

  assign bus.tx_data   = r_shift[FRAME_W-1 -: TX_WORD_W];
  assign bus.tx_valid  = (r_state == ST_SEND);
  assign bus.din_ready = r_din_ready;
  assign bus.overflow  = r_overflow;
  assign bus.level     = 4'(w_level);

endmodule

// File: tb/tb_pcileech_tx_serializer.sv
// tb/tb_pcileech_tx_serializer.sv - scoreboard bench for the transmit serializer
module tb_pcileech_tx_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcileech_tx_serializer_if bus_if ();

  pcileech_tx_serializer #(.DEPTH(8), .AFULL_MARGIN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Beat monitor: pops the scoreboard on every accepted beat, and checks hold during stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(bus_if.tx_valid), 64'd1);
        check("stall_hold_data", 64'(bus_if.tx_data), 64'(prev_data));
      end
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(bus_if.tx_data), 64'hDEAD_0000_0000);
        else check("beat", 64'(bus_if.tx_data), 64'(exp_q.pop_front()));
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_data  = bus_if.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [255:0] f);
    for (int k = 0; k < 8; k++) exp_q.push_back(f[255 - 32*k -: 32]);
  endtask

  task automatic push(input logic [255:0] f, input logic accepted);
    bus_if.din       = f;
    bus_if.din_valid = 1'b1;
    if (accepted) enqueue(f);
    tick();
    bus_if.din_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check({name, "_idle_after"}, 64'(bus_if.tx_valid), 64'd0);
    tick();
  endtask

  function automatic logic [255:0] mk(input logic [7:0] id);
    logic [255:0] f;
    f[255:224] = {8'h5A, id, 16'hE5E5};
    for (int k = 0; k < 7; k++) f[32*k +: 32] = {id, 8'hD0, 8'(k), 8'h3C};
    return f;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] f1;
    logic [255:0] ffill;
    int first, last, cnt;

    f1    = {32'h1234E678, 32'hA0000000, 32'hA0000001, 32'hA0000002,
             32'hA0000003, 32'hA0000004, 32'hA0000005, 32'h00000007};
    ffill = {32'hFFFFFFEF, {7{32'hFFFFFFFF}}};

    rst              = 1'b1;
    bus_if.din       = '0;
    bus_if.din_valid = 1'b0;
    bus_if.tx_ready  = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_din_ready", 64'(bus_if.din_ready), 64'd0);
    check("rst_tx_valid", 64'(bus_if.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus_if.tx_data), 64'd0);
    check("rst_overflow", 64'(bus_if.overflow), 64'd0);
    check("rst_level", 64'(bus_if.level), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("din_ready_still_low", 64'(bus_if.din_ready), 64'd0);
    tick();
    @(negedge clk);
    check("din_ready_rise", 64'(bus_if.din_ready), 64'd1);
    tick();

    // Single frame, latency N+2
    bus_if.din       = f1;
    bus_if.din_valid = 1'b1;
    enqueue(f1);
    @(negedge clk);
    check("lat_n_valid", 64'(bus_if.tx_valid), 64'd0);
    tick();
    bus_if.din_valid = 1'b0;
    @(negedge clk);
    check("lat_n1_valid", 64'(bus_if.tx_valid), 64'd0);
    check("lat_n1_level", 64'(bus_if.level), 64'd1);
    tick();
    @(negedge clk);
    check("lat_n2_valid", 64'(bus_if.tx_valid), 64'd1);
    check("lat_n2_status", 64'(bus_if.tx_data), 64'h1234E678);
    tick();
    wait_drain("single", 50);

    // Three frames at 8-cycle spacing: 24 contiguous beats
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 8 == 0 && i < 24) begin
        bus_if.din       = mk(8'(i));
        bus_if.din_valid = 1'b1;
        enqueue(mk(8'(i)));
      end else begin
        bus_if.din_valid = 1'b0;
      end
      @(negedge clk);
      if (bus_if.tx_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
    end
    check("b2b_count", 64'(cnt), 64'd24);
    check("b2b_first", 64'(first), 64'd2);
    check("b2b_span", 64'(last - first + 1), 64'd24);
    wait_drain("b2b", 20);

    // tx_ready toggling: 16 cycles for one frame
    bus_if.tx_ready = 1'b0;
    push(mk(8'h40), 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      bus_if.tx_ready = (i % 2 == 1);
      tick();
    end
    bus_if.tx_ready = 1'b0;
    @(negedge clk);
    check("toggle_done_valid", 64'(bus_if.tx_valid), 64'd0);
    check("toggle_done_q", 64'(exp_q.size()), 64'd0);
    tick();

    // Fill with the sink stalled; first frame sits in the shift register
    for (int i = 1; i <= 6; i++) push(mk(8'h80 + 8'(i)), 1'b1);
    @(negedge clk);
    check("fill_level5", 64'(bus_if.level), 64'd5);
    check("fill_ready5", 64'(bus_if.din_ready), 64'd1);
    push(mk(8'h87), 1'b1);
    @(negedge clk);
    check("fill_level6", 64'(bus_if.level), 64'd6);
    check("fill_ready6", 64'(bus_if.din_ready), 64'd0);
    push(mk(8'h88), 1'b1);
    push(mk(8'h89), 1'b1);
    @(negedge clk);
    check("fill_level8", 64'(bus_if.level), 64'd8);
    check("fill_no_ovf", 64'(bus_if.overflow), 64'd0);

    // Push exactly when the head frame's last beat is accepted
    bus_if.tx_ready = 1'b1;
    repeat (7) tick();
    push(mk(8'h8A), 1'b1);
    bus_if.tx_ready = 1'b0;
    @(negedge clk);
    check("pushpop_level", 64'(bus_if.level), 64'd8);
    check("pushpop_no_ovf", 64'(bus_if.overflow), 64'd0);
    tick();

    push(mk(8'h8B), 1'b0);
    @(negedge clk);
    check("ovf_set", 64'(bus_if.overflow), 64'd1);
    check("ovf_level", 64'(bus_if.level), 64'd8);
    tick();
    bus_if.tx_ready = 1'b1;
    wait_drain("fill", 200);
    check("ovf_sticky", 64'(bus_if.overflow), 64'd1);

    // Reset at beat 3 with two frames queued
    push(mk(8'hC1), 1'b1);
    push(mk(8'hC2), 1'b1);
    push(mk(8'hC3), 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus_if.tx_valid), 64'd0);
    check("mid_rst_level", 64'(bus_if.level), 64'd0);
    check("mid_rst_ready", 64'(bus_if.din_ready), 64'd0);
    check("mid_rst_ovf", 64'(bus_if.overflow), 64'd0);
    tick();
    @(negedge clk);
    check("mid_rst_ready_rise", 64'(bus_if.din_ready), 64'd1);
    tick();
    push(ffill, 1'b1);
    wait_drain("post_rst_filler", 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
